// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file and the decode stage.
package regfile_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  // Address width that never collapses to zero bits for a single-entry array.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/regfile_mp_bypass_if.sv
// Decode/writeback-facing bus of the register file: read ports, write, reserve, clear.
interface regfile_mp_bypass_if
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NUM_RD = 2
);
  localparam int AW = clog2_min1(DEPTH);

  // No valid/ready: wr_en, rsv_en and clr_req are single-cycle strobes accepted
  // at the posedge they are high (dropped while clr_busy); reads are combinational
  // and rd_data/rd_pend are valid in the same cycle as rd_addr.
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_pend;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic                    rsv_en;
  logic [AW-1:0]           rsv_addr;
  logic                    clr_req;
  logic                    clr_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    input  rd_data, rd_pend, clr_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    output rd_data, rd_pend, clr_busy
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero-register, range, bypass and pending-mask selection.
module regfile_rd_port #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] mem_word,
  input  logic             pend_bit,
  input  logic             in_range,
  input  logic             busy,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_pend
);

  logic hit_zero;
  logic hit_byp;

  always_comb begin
    hit_zero = ZERO_REG && (addr == '0);
    hit_byp  = BYPASS && wr_en && (wr_addr == addr);
    rd_data  = '0;
    rd_pend  = 1'b0;
    // The write being retired this cycle is the newest value and also ends the wait.
    if (!busy && in_range && !hit_zero) begin
      rd_data = hit_byp ? wr_data : mem_word;
      rd_pend = pend_bit & ~hit_byp;
    end
  end

endmodule

// File: rtl/regfile_mp_bypass.sv
// Multi-read-port register file with write bypass, zero register, pending
// scoreboard and a sequential clear engine that runs after reset or on request.
module regfile_mp_bypass
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_mp_bypass_if.slave  bus,
  output clr_state_e          dbg_state
);

  localparam int            AW       = clog2_min1(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_e       state_q;
  logic [AW-1:0]    clr_idx_q;
  logic             clr_busy_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  logic             idle;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  logic [WIDTH-1:0] mem_word [NUM_RD];
  logic [NUM_RD-1:0] pend_bit;
  logic [NUM_RD-1:0] in_range;

  assign idle = (state_q == CLR_IDLE);

  // A clear request restarts the sweep from entry 0 even if one is already running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLR_RUN;
      clr_idx_q  <= '0;
      clr_busy_q <= 1'b1;
    end else if (bus.clr_req) begin
      state_q    <= CLR_RUN;
      clr_idx_q  <= '0;
      clr_busy_q <= 1'b1;
    end else if (state_q == CLR_RUN) begin
      if (clr_idx_q == LAST_IDX) begin
        state_q    <= CLR_IDLE;
        clr_busy_q <= 1'b0;
      end else begin
        clr_idx_q <= clr_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_idx_q;
    mem_wdata = '0;
    if (!idle) begin
      mem_we = 1'b1;
    end else if (bus.wr_en && !(ZERO_REG && bus.wr_addr == '0)) begin
      mem_we    = 1'b1;
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.wr_data;
    end
  end

  // Address decode by match keeps out-of-range addresses harmless for non-pow2 DEPTH.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (mem_we && mem_waddr == AW'(e)) mem_q[e] <= mem_wdata;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (idle) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (bus.wr_en && bus.wr_addr == AW'(e))   pend_d[e] = 1'b0;
        if (bus.rsv_en && bus.rsv_addr == AW'(e)) pend_d[e] = 1'b1;
      end
      if (bus.clr_req) pend_d = '0;
    end
    if (ZERO_REG) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      mem_word[p] = '0;
      pend_bit[p] = 1'b0;
      in_range[p] = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        if (bus.rd_addr[p*AW +: AW] == AW'(e)) begin
          mem_word[p] = mem_q[e];
          pend_bit[p] = pend_q[e];
          in_range[p] = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    regfile_rd_port #(
      .WIDTH    (WIDTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .addr     (bus.rd_addr[gi*AW +: AW]),
      .mem_word (mem_word[gi]),
      .pend_bit (pend_bit[gi]),
      .in_range (in_range[gi]),
      .busy     (clr_busy_q),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .rd_data  (bus.rd_data[gi*WIDTH +: WIDTH]),
      .rd_pend  (bus.rd_pend[gi])
    );
  end

  assign bus.clr_busy = clr_busy_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Randomised and directed bench for regfile_mp_bypass, checked against an array-level model.
module tb_regfile_mp_bypass;
  import regfile_pkg::*;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = clog2_min1(DEPTH);
  localparam int PW     = NUM_RD*WIDTH + NUM_RD + 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  clr_state_e dbg_state;

  always #5 clk = ~clk;

  regfile_mp_bypass_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();

  regfile_mp_bypass #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_pend [DEPTH];
  int               m_busy;
  bit               m_valid;

  logic [PW-1:0] exp_q[$];
  string         tag_q[$];
  int            tests;
  int            fails;
  string         phase;

  // Expected {rd_data, rd_pend, clr_busy, state==CLR_RUN} for the inputs now applied.
  function automatic logic [PW-1:0] model_outputs();
    logic [NUM_RD*WIDTH-1:0] d;
    logic [NUM_RD-1:0]       p;
    bit                      busy;
    bit                      byp;
    int                      a;
    d    = '0;
    p    = '0;
    busy = (m_busy > 0);
    for (int i = 0; i < NUM_RD; i++) begin
      a = int'(bus.rd_addr[i*AW +: AW]);
      if (!busy && a != 0 && a < DEPTH) begin
        byp = bus.wr_en && (int'(bus.wr_addr) == a);
        d[i*WIDTH +: WIDTH] = byp ? bus.wr_data : m_mem[a];
        p[i] = m_pend[a] && !byp;
      end
    end
    return {d, p, busy, busy};
  endfunction

  // Clearing is modelled as instantaneous: contents are invisible until the sweep ends.
  task automatic model_edge();
    if (!rst_n || bus.clr_req) begin
      m_busy  = DEPTH;
      m_valid = 1'b1;
      for (int e = 0; e < DEPTH; e++) begin
        m_mem[e]  = '0;
        m_pend[e] = 1'b0;
      end
    end else if (m_busy > 0) begin
      m_busy--;
    end else begin
      if (bus.wr_en) begin
        if (bus.wr_addr != 0) m_mem[bus.wr_addr] = bus.wr_data;
        m_pend[bus.wr_addr] = 1'b0;
      end
      if (bus.rsv_en && bus.rsv_addr != 0) m_pend[bus.rsv_addr] = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    if (m_valid) begin
      exp_q.push_back(model_outputs());
      tag_q.push_back(phase);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.clr_req  = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic drive_wr(input int a, input logic [WIDTH-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
  endtask

  task automatic drive_rsv(input int a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(a);
  endtask

  task automatic rand_cycles(input int n, input int clr_pct);
    int wa;
    for (int k = 0; k < n; k++) begin
      set_idle();
      wa = $urandom_range(0, DEPTH-1);
      if ($urandom_range(0, 1) == 1) drive_wr(wa, $urandom);
      if ($urandom_range(0, 2) == 0) drive_rsv($urandom_range(0, DEPTH-1));
      bus.clr_req = ($urandom_range(0, 99) < clr_pct);
      set_rd(($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH-1),
             $urandom_range(0, DEPTH-1));
      cycle();
    end
    set_idle();
  endtask

  task automatic sweep();
    set_idle();
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(a, a + 1);
      cycle();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [PW-1:0] exp_v;
    logic [PW-1:0] got_v;
    string         tag;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      got_v = {bus.rd_data, bus.rd_pend, bus.clr_busy, dbg_state == CLR_RUN};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL %s @%0t: got {data,pend,busy,state}=%h expected %h",
                 tag, $time, got_v, exp_v);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tests   = 0;
    fails   = 0;
    m_valid = 1'b0;
    m_busy  = 0;
    set_idle();
    set_rd(0, 0);

    phase = "reset";
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      set_rd($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH-1));
      cycle();
    end
    phase = "reset_sweep";
    sweep();

    phase = "wr_bypass";
    drive_wr(5, 32'hDEAD_BEEF);
    set_rd(5, 5);
    cycle();
    phase = "wr_after";
    set_idle();
    set_rd(5, 6);
    cycle();

    phase = "zero_reg";
    drive_wr(0, 32'h0000_1234);
    drive_rsv(0);
    set_rd(0, 0);
    cycle();
    set_idle();
    cycle();

    phase = "pend";
    drive_rsv(7);
    set_rd(7, 7);
    cycle();
    set_idle();
    cycle();
    drive_wr(7, 32'h0000_00A5);
    drive_rsv(7);
    cycle();
    set_idle();
    cycle();
    drive_wr(7, 32'h0000_005A);
    cycle();
    set_idle();
    cycle();

    phase = "random";
    rand_cycles(600, 1);
    set_idle();
    repeat (DEPTH + 1) cycle();

    phase = "clr_mid";
    for (int r = 1; r <= 3; r++) begin
      drive_wr(r, $urandom);
      set_rd(r, r);
      cycle();
    end
    set_idle();
    set_rd(1, 2);
    bus.clr_req = 1'b1;
    cycle();
    rand_cycles(9, 0);
    bus.clr_req = 1'b1;
    cycle();
    rand_cycles(DEPTH + 2, 0);
    phase = "clr_sweep";
    sweep();

    phase = "rst_mid";
    rand_cycles(20, 0);
    bus.clr_req = 1'b1;
    cycle();
    rand_cycles(15, 0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    rand_cycles(DEPTH + 2, 0);
    phase = "rst_sweep";
    sweep();

    phase = "random_tail";
    rand_cycles(200, 2);
    set_idle();
    repeat (DEPTH + 1) cycle();

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
